// File: rtl/m_fetch_pkg.sv
// Shared fetch types: FSM state encoding and the queued {pc, instruction} record.
// The FAULT state exists only when M_FETCH_ALIGN_CHECK_EN is defined.
package p_fetch;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DROP  = 2'd2
`ifdef M_FETCH_ALIGN_CHECK_EN
    , ST_FAULT = 2'd3
`endif
  } e_fetch_state;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } s_fetched;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/m_fetch_queue.sv
// Synchronous prefetch FIFO of s_fetched records with flush; DEPTH must be a power of two.
module m_fetch_queue
  import p_fetch::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  s_fetched               push_data,
  input  logic                   pop,
  output s_fetched               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  s_fetched        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // Flush wins over any same-cycle push or pop.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/m_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a prefetch queue.
// Optional misaligned-redirect trap enabled by M_FETCH_ALIGN_CHECK_EN.
module m_fetch
  import p_fetch::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
`ifdef M_FETCH_ALIGN_CHECK_EN
  output logic        fault,
`endif
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  e_fetch_state  state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   pc_q, pc_d;
`ifdef M_FETCH_ALIGN_CHECK_EN
  logic          fault_q, fault_d;
`endif

  logic          push, pop, q_full, q_empty;
  logic [CW-1:0] q_count, occ_after_ack;
  logic [31:0]   target;
  s_fetched      push_word, head;

  assign target     = redirect_pc & ALIGN_MASK;
  assign push_word  = '{pc: mem_addr_q, instruction: mem_rdata};
  // A redirect hides the head this cycle, which also suppresses the pop.
  assign inst_valid = !q_empty && !redirect;
  assign pop        = inst_valid && inst_ready;

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    pc_d          = pc_q;
    push          = 1'b0;
    occ_after_ack = q_count + CW'(1) - CW'(pop);
`ifdef M_FETCH_ALIGN_CHECK_EN
    fault_d       = fault_q;
`endif
    if (redirect) begin
      pc_d = target;
`ifdef M_FETCH_ALIGN_CHECK_EN
      fault_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d   = ST_FAULT;
        fault_d   = 1'b1;
        mem_req_d = mem_req_q && !mem_ack;
      end else
`endif
      if (mem_req_q && !mem_ack) begin
        state_d = ST_DROP;
      end else begin
        state_d    = ST_REQ;
        mem_req_d  = 1'b1;
        mem_addr_d = target;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!q_full || pop) begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            push = 1'b1;
            pc_d = mem_addr_q + PC_STEP;
            // Chain the next request only if it still fits beside the queued words.
            if (occ_after_ack < CW'(DEPTH)) begin
              mem_addr_d = mem_addr_q + PC_STEP;
            end else begin
              state_d   = ST_IDLE;
              mem_req_d = 1'b0;
            end
          end
        end
        ST_DROP: begin
          if (mem_ack) begin
            state_d    = ST_REQ;
            mem_addr_d = pc_q;
          end
        end
`ifdef M_FETCH_ALIGN_CHECK_EN
        ST_FAULT: begin
          if (mem_ack) mem_req_d = 1'b0;
        end
`endif
        default: begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_VECTOR;
      pc_q       <= RESET_VECTOR;
`ifdef M_FETCH_ALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      pc_q       <= pc_d;
`ifdef M_FETCH_ALIGN_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  m_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instruction = q_empty ? 32'h0 : head.instruction;
  assign inst_pc     = q_empty ? 32'h0 : head.pc;
`ifdef M_FETCH_ALIGN_CHECK_EN
  assign fault       = fault_q;
`endif

endmodule

// File: doc/m_fetch.md
M_FETCH -- requirements
Module: m_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning prefetch queue entries (power of two, at least 2).
REQ-003 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports: mem_req  output  1  instruction read request.
REQ-006 SHALL have ports: mem_addr  output  32  word-aligned read address.
REQ-007 SHALL have ports: mem_ack  input  1  read completes this cycle when mem_req && mem_ack.
REQ-008 SHALL have ports: mem_rdata  input  32  instruction word, valid when mem_ack.
REQ-009 SHALL have ports: inst_valid  output  1  instruction offered to the decoder.
REQ-010 SHALL have ports: inst_ready  input  1  decoder accepts the instruction.
REQ-011 SHALL have ports: instruction  output  32  word presented to m_decoder.
REQ-012 SHALL have ports: inst_pc  output  32  address of the instruction.
REQ-013 SHALL have ports: redirect  input  1  flush and restart fetch.
REQ-014 SHALL have ports: redirect_pc  input  32  new fetch address.
REQ-015 SHALL have ports: fault  output  1  misaligned redirect, only when M_FETCH_ALIGN_CHECK_EN is defined.

Function
REQ-016 SHALL implement states IDLE (no request), REQ (mem_req high, awaiting ack), DROP (stale request awaiting ack), and FAULT.
REQ-017 SHALL hold mem_req and mem_addr stable from assertion until the cycle mem_req && mem_ack.
REQ-018 SHALL assert mem_req only when queue occupancy plus outstanding requests is less than DEPTH; at most one request is outstanding.
REQ-019 SHALL, on an ack in REQ, push {mem_addr, mem_rdata} into the queue, advance fetch pc by 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), and issue the next request in the same cycle if space allows.
REQ-020 SHALL drive inst_valid from queue non-empty and pop on inst_valid && inst_ready; a push and a pop in the same cycle SHALL both occur, with occupancy unchanged.
REQ-021 SHALL sustain one instruction per cycle with zero-wait memory (ack in the request cycle) and a continuously ready decoder.
REQ-022 SHALL place a fetched word at the queue output no earlier than the cycle after its ack.
REQ-023 SHALL, on redirect, force inst_valid low that cycle, flush the queue next cycle, and set fetch pc to redirect_pc.
REQ-024 SHALL, on redirect, enter DROP if a request is outstanding and not acked that cycle; otherwise enter REQ with mem_addr = redirect_pc the next cycle.
REQ-025 SHALL discard the rdata acked in DROP, then issue the redirect target request.
REQ-026 SHALL give redirect priority over a same-cycle ack (discard the word) and over a same-cycle pop (the pop is ignored).
REQ-027 SHALL let the latest redirect win when a new redirect arrives in DROP.

Reset
REQ-028 SHALL on rst set state IDLE, empty the queue, set fetch pc to RESET_VECTOR, and drive mem_req=0, inst_valid=0, fault=0, and instruction/inst_pc=0.
REQ-029 SHALL assert mem_req with mem_addr=RESET_VECTOR in the first cycle after rst deasserts.
REQ-030 SHALL let reset mid-transaction abandon the outstanding request without waiting for ack.

Configuration
REQ-031 SHALL implement macro M_FETCH_ALIGN_CHECK_EN.
REQ-032 With M_FETCH_ALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0] != 0 SHALL enter FAULT, assert fault, and issue no requests until the next aligned redirect, which clears fault.
REQ-033 Without M_FETCH_ALIGN_CHECK_EN, the fault port and FAULT state SHALL be absent, and redirect_pc[1:0] SHALL be forced to zero.

Structure
REQ-034 SHALL place enum e_fetch_state and struct s_fetched {pc, instruction} in shared package p_fetch.
REQ-035 SHALL implement the queue as sub-module m_fetch_queue (synchronous FIFO of s_fetched, with flush, push, pop, full, and empty).

Verification
REQ-036 Cover reset release with a zero-wait, always-acking memory: mem_addr SHALL go 0,4,8,...; inst_valid first high 2 cycles after reset; one instruction per cycle thereafter.
REQ-037 Cover inst_ready held low, DEPTH=2: exactly 2 acks SHALL occur, then mem_req stays low until a pop.
REQ-038 Cover redirect to 32'h100 while the request to 8 is unacked for 3 cycles: the ack'd word SHALL be discarded, the next mem_addr SHALL be 32'h100, and the first inst_pc out SHALL be 32'h100.
REQ-039 Cover redirect with a simultaneous ack and pop: inst_valid SHALL be low that cycle and neither word SHALL be delivered.
REQ-040 Cover fetch from 32'hFFFF_FFFC: the next mem_addr SHALL be 32'h0.
REQ-041 Cover, with M_FETCH_ALIGN_CHECK_EN, redirect to 32'h102: fault SHALL be high and mem_req low; a redirect to 32'h200 SHALL clear fault and fetch 32'h200.
